mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ramWidth, default 8, data word width.
REQ-002 Parameter addrSize, default 8, address width.
REQ-003 Parameter timeoutCycles, default 64, maximum WAIT cycles before abort; legal range 2..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 reqValid  input  1  requester presents an access.
REQ-007 reqWrite  input  1  1 = write, 0 = read.
REQ-008 reqIndirect  input  1  indirect-addressing flag for the access.
REQ-009 reqAddr  input  addrSize  access address.
REQ-010 reqData  input  ramWidth  write data.
REQ-011 reqReady  output  1  unit can accept a request this cycle.
REQ-012 respValid  output  1  response available.
REQ-013 respReady  input  1  requester consumes the response.
REQ-014 respData  output  ramWidth  read data; 0 for writes and aborts.
REQ-015 respErr  output  1  access aborted by timeout.
REQ-016 errCount  output  8  saturating count of timeouts since reset.
REQ-017 memCntrl  output  2  memory-module command: 00 idle, 01 read, 10 write, 11 never driven.
REQ-018 memAddr  output  addrSize  memory-module address.
REQ-019 memDataIn  output  ramWidth  memory-module write data.
REQ-020 memIsIndirect  output  1  memory-module indirect flag.
REQ-021 memDataOut  input  ramWidth  memory-module read data.
REQ-022 memDataReady  input  1  memory-module completion strobe.

Function
REQ-023 FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-024 IDLE: reqReady=1, memCntrl=00; reqValid at edge k latches reqWrite/reqIndirect/reqAddr/reqData and moves to WAIT.
REQ-025 WAIT: memCntrl = 01 (read) or 10 (write) from cycle k+1; memAddr, memDataIn, memIsIndirect hold latched values, stable until leaving WAIT; reqReady=0.
REQ-026 WAIT: memDataReady sampled high at edge m -> memCntrl=00 and respValid=1 from cycle m+1; a read captures memDataOut at edge m into respData; a write sets respData=0.
REQ-027 WAIT timeout counter starts at 0 on entry, increments each WAIT cycle; reaching timeoutCycles without memDataReady -> RESP with respErr=1, respData=0, errCount+1 (saturates at 255).
REQ-028 memDataReady and timeout on the same edge: memDataReady wins, respErr=0, errCount unchanged.
REQ-029 RESP: respValid, respData, respErr stable until respReady; respReady at edge n -> IDLE, respValid=0 from cycle n+1.
REQ-030 memDataReady outside WAIT is ignored; no state or output change.
REQ-031 reqValid outside IDLE is not accepted; reqReady=0 in WAIT and RESP.
REQ-032 Minimum request-to-response latency 2 cycles (accept at k, memDataReady at k+1, respValid at k+2); back-to-back throughput one access per 3 cycles minimum.
REQ-033 memAddr/memDataIn/memIsIndirect retain their last values in IDLE and RESP; memCntrl=00 there.

Reset
REQ-034 clr at an edge forces IDLE in the next cycle regardless of state, including mid-WAIT (outstanding access abandoned, memCntrl=00 next cycle).
REQ-035 Reset values: reqReady=1, respValid=0, respData=0, respErr=0, errCount=0, memCntrl=00, memAddr=0, memDataIn=0, memIsIndirect=0, timeout counter=0.
REQ-036 clr has priority over all other inputs on the same edge.

Structure
REQ-037 Shared package holds memCntrl encodings (MEM_IDLE=00, MEM_READ=01, MEM_WRITE=10) and FSM state encodings; the memory module's controller uses the same package constants.
REQ-038 One sub-module, mem_timeout_counter (load/enable/expired, width 8), instantiated once; all other logic flat.

Verification
REQ-039 Read: reqAddr=0x3C, reqWrite=0, memory returns memDataOut=0xA5 with memDataReady 3 cycles after memCntrl=01 -> respData=0xA5, respErr=0, memCntrl back to 00 the cycle respValid rises.
REQ-040 Write: reqAddr=0x10, reqData=0x5A, reqIndirect=1 -> memCntrl=10, memAddr=0x10, memDataIn=0x5A, memIsIndirect=1 held until memDataReady; respData=0.
REQ-041 Timeout: timeoutCycles=4, memDataReady never asserted -> respValid after 4 WAIT cycles with respErr=1, errCount=1; repeat 300 times -> errCount=255.
REQ-042 Coincidence: memDataReady on the timeout edge -> respErr=0, errCount unchanged, respData=memDataOut.
REQ-043 Backpressure and stray strobes: respReady held 0 for 5 cycles -> response stable; memDataReady pulsed in IDLE and RESP -> no change.
REQ-044 Reset mid-WAIT: clr at third WAIT cycle -> next cycle IDLE, memCntrl=00, reqReady=1, respValid=0, errCount=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit and the memory-module controller.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int ERR_COUNT_WIDTH = 8;

    function automatic logic [ERR_COUNT_WIDTH-1:0] sat_inc(input logic [ERR_COUNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_access_unit_timeout_counter.sv
// Counts WAIT cycles; expired_o flags the last permitted cycle so the FSM leaves on that edge.
module mem_timeout_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic srst,
    input  logic load_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding request/response bridge to a memory module, with WAIT timeout and
// saturating error counter. All outputs come straight from registers.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ramWidth      = 8,
    parameter int addrSize      = 8,
    parameter int timeoutCycles = 64
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                reqValid,
    input  logic                reqWrite,
    input  logic                reqIndirect,
    input  logic [addrSize-1:0] reqAddr,
    input  logic [ramWidth-1:0] reqData,
    output logic                reqReady,
    output logic                respValid,
    input  logic                respReady,
    output logic [ramWidth-1:0] respData,
    output logic                respErr,
    output logic [7:0]          errCount,
    output logic [1:0]          memCntrl,
    output logic [addrSize-1:0] memAddr,
    output logic [ramWidth-1:0] memDataIn,
    output logic                memIsIndirect,
    input  logic [ramWidth-1:0] memDataOut,
    input  logic                memDataReady
);

    state_e              state_q, state_d;
    mem_cmd_e            mem_cntrl_q, mem_cntrl_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [ramWidth-1:0] resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;
    logic [7:0]          err_count_q, err_count_d;
    logic [addrSize-1:0] mem_addr_q, mem_addr_d;
    logic [ramWidth-1:0] mem_data_in_q, mem_data_in_d;
    logic                mem_indirect_q, mem_indirect_d;
    logic                timeout_expired;

    // Held at zero outside WAIT so every access starts a fresh count.
    mem_timeout_counter #(
        .WIDTH (8),
        .LIMIT (timeoutCycles)
    ) u_timeout (
        .clk       (clk),
        .srst      (clr),
        .load_i    (state_q != ST_WAIT),
        .enable_i  (state_q == ST_WAIT),
        .expired_o (timeout_expired)
    );

    always_comb begin
        state_d        = state_q;
        mem_cntrl_d    = mem_cntrl_q;
        req_ready_d    = req_ready_q;
        resp_valid_d   = resp_valid_q;
        resp_data_d    = resp_data_q;
        resp_err_d     = resp_err_q;
        err_count_d    = err_count_q;
        mem_addr_d     = mem_addr_q;
        mem_data_in_d  = mem_data_in_q;
        mem_indirect_d = mem_indirect_q;

        unique case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    state_d        = ST_WAIT;
                    req_ready_d    = 1'b0;
                    mem_cntrl_d    = reqWrite ? MEM_WRITE : MEM_READ;
                    mem_addr_d     = reqAddr;
                    mem_data_in_d  = reqData;
                    mem_indirect_d = reqIndirect;
                end
            end
            ST_WAIT: begin
                // A completion on the timeout edge is a success, so it is tested first.
                if (memDataReady) begin
                    state_d      = ST_RESP;
                    mem_cntrl_d  = MEM_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = (mem_cntrl_q == MEM_READ) ? memDataOut : '0;
                end else if (timeout_expired) begin
                    state_d      = ST_RESP;
                    mem_cntrl_d  = MEM_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = '0;
                    err_count_d  = sat_inc(err_count_q);
                end
            end
            ST_RESP: begin
                if (respReady) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_cntrl_d = MEM_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q        <= ST_IDLE;
            mem_cntrl_q    <= MEM_IDLE;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_err_q     <= 1'b0;
            err_count_q    <= '0;
            mem_addr_q     <= '0;
            mem_data_in_q  <= '0;
            mem_indirect_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_cntrl_q    <= mem_cntrl_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_err_q     <= resp_err_d;
            err_count_q    <= err_count_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_in_q  <= mem_data_in_d;
            mem_indirect_q <= mem_indirect_d;
        end
    end

    assign reqReady      = req_ready_q;
    assign respValid     = resp_valid_q;
    assign respData      = resp_data_q;
    assign respErr       = resp_err_q;
    assign errCount      = err_count_q;
    assign memCntrl      = mem_cntrl_q;
    assign memAddr       = mem_addr_q;
    assign memDataIn     = mem_data_in_q;
    assign memIsIndirect = mem_indirect_q;

endmodule
